// File: rtl/div_issue_ctrl.sv
// Issue/sequencer for a shared radix-2 restoring divider: picks the oldest ready
// DIV/DIVU/REM/REMU reservation-station entry, iterates XLEN steps, hands the result to the CDB.
module div_issue_ctrl #(
  parameter int NUM_RS = 4,
  parameter int ROB_W  = 6,
  parameter int XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [ROB_W-1:0]         rob_head,
  input  logic [NUM_RS-1:0]        rs_ready,
  input  logic [NUM_RS*ROB_W-1:0]  rs_rob,
  input  logic [NUM_RS*2-1:0]      rs_op,
  input  logic [NUM_RS*XLEN-1:0]   rs_a,
  input  logic [NUM_RS*XLEN-1:0]   rs_b,
  output logic [NUM_RS-1:0]        rs_clear,
  output logic                     busy,
  output logic                     res_valid,
  output logic [ROB_W-1:0]         res_rob,
  output logic [XLEN-1:0]          res_data,
  input  logic                     res_ack,
  output logic [1:0]               dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int SEL_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROB_W-1:0]  rob_q, rob_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   bmag_q, bmag_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;

  // Oldest-first pick: age is distance from the ROB head modulo 2^ROB_W, so the
  // subtraction wraps naturally; strict '<' keeps the lowest index on ties.
  logic              found;
  logic [SEL_W-1:0]  sel;
  logic [ROB_W-1:0]  best_age;

  always_comb begin
    logic [ROB_W-1:0] age;
    found    = 1'b0;
    sel      = '0;
    best_age = '0;
    age      = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      age = rs_rob[i*ROB_W +: ROB_W] - rob_head;
      if (rs_ready[i] && (!found || (age < best_age))) begin
        found    = 1'b1;
        sel      = SEL_W'(i);
        best_age = age;
      end
    end
  end

  logic [1:0]       sel_op;
  logic [ROB_W-1:0] sel_rob;
  logic [XLEN-1:0]  sel_a, sel_b, a_mag, b_mag;
  logic             sel_signed, sel_is_rem, a_neg, b_neg, div_by_zero, ovf, accept;

  assign sel_op      = rs_op[int'(sel)*2 +: 2];
  assign sel_rob     = rs_rob[int'(sel)*ROB_W +: ROB_W];
  assign sel_a       = rs_a[int'(sel)*XLEN +: XLEN];
  assign sel_b       = rs_b[int'(sel)*XLEN +: XLEN];
  assign sel_signed  = ~sel_op[0];
  assign sel_is_rem  = sel_op[1];
  assign a_neg       = sel_signed & sel_a[XLEN-1];
  assign b_neg       = sel_signed & sel_b[XLEN-1];
  assign a_mag       = a_neg ? (~sel_a + 1'b1) : sel_a;
  assign b_mag       = b_neg ? (~sel_b + 1'b1) : sel_b;
  assign div_by_zero = (sel_b == '0);
  assign ovf         = sel_signed && (sel_a == {1'b1, {(XLEN-1){1'b0}}}) && (sel_b == '1);
  assign accept      = (state_q == IDLE) && !flush && found;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, quo_next;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, bmag_q};
  assign q_bit     = ~rem_diff[XLEN];
  assign rem_next  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_next  = {quo_q[XLEN-2:0], q_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rob_d      = rob_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bmag_d     = bmag_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rob_d    = sel_rob;
          is_rem_d = sel_is_rem;
          if (div_by_zero) begin
            res_data_d = sel_is_rem ? sel_a : '1;
            state_d    = DONE;
          end else if (ovf) begin
            res_data_d = sel_is_rem ? '0 : sel_a;
            state_d    = DONE;
          end else begin
            quo_d     = a_mag;
            bmag_d    = b_mag;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          if (is_rem_q) res_data_d = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
          else          res_data_d = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rob_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bmag_q     <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rob_q      <= rob_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bmag_q     <= bmag_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      res_data_q <= res_data_d;
    end
  end

  // CDB handshake: res_valid stays high with res_rob/res_data frozen until a cycle
  // with res_ack high; the transfer happens in that cycle and valid drops next cycle.
  assign rs_clear  = accept ? (NUM_RS'(1) << sel) : '0;
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_rob   = rob_q;
  assign res_data  = res_data_q;
  assign dbg_state = state_q;

endmodule
